mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   MEM-stage data-memory access controller. Takes load/store requests from the EX/MEM buffer and runs a
//   req/ack transaction on the data bus. It drives mem_stall into the hazard unit, which freezes all four
//   pipeline buffers until the access completes. It returns load data toward the MEM/WB buffer.
//   A bounded timeout converts a hung bus into a bus_err pulse so the pipeline cannot lock up.
// PARAMETERS
//   ADDR_W   32  address width
//   DATA_W   32  data width
//   TIMEOUT  64  max BUSY cycles awaiting bus_ack before abort; 0 = timeout disabled
// PORTS
//   clk          in   1       single clock, all state updates on rising edge
//   rst          in   1       synchronous, active-high reset
//   mem_rd       in   1       load present in MEM stage
//   mem_wr       in   1       store present in MEM stage (wins if mem_rd also high)
//   addr         in   ADDR_W  access address
//   wdata        in   DATA_W  store data
//   mem_stall    out  1       to hazard unit; high = hold pipeline
//   rdata        out  DATA_W  load result, held until next load completes
//   rdata_valid  out  1       1-cycle pulse: load completed, rdata valid this cycle
//   bus_err      out  1       1-cycle pulse: access aborted by timeout
//   bus_req      out  1       bus request, held until ack or abort
//   bus_we       out  1       1 = write, 0 = read; stable while bus_req high
//   bus_addr     out  ADDR_W  registered address; stable while bus_req high
//   bus_wdata    out  DATA_W  registered store data; stable while bus_req high
//   bus_ack      in   1       bus completion, sampled only while bus_req high
//   bus_rdata    in   DATA_W  read data, valid with bus_ack on reads
// BEHAVIOUR
//   Reset: state=IDLE; bus_req, bus_we, rdata_valid, bus_err = 0; bus_addr, bus_wdata, rdata = 0; timer = 0.
//   FSM states: IDLE, BUSY, DONE, ERR.
//   IDLE: if mem_rd|mem_wr -> latch addr/wdata/we into bus regs, timer=0, next BUSY; else stay.
//   BUSY: bus_req=1. bus_ack -> next DONE (read: rdata<=bus_rdata). Else if TIMEOUT!=0 and
//     timer==TIMEOUT-1 -> next ERR. Else timer++.
//   DONE: bus_req=0; rdata_valid=1 if the access was a read; mem_stall=0; next IDLE unconditionally.
//     mem_rd/mem_wr are ignored here because they still describe the completing op.
//   ERR: bus_req=0; bus_err=1; rdata<=0; mem_stall=0; next IDLE.
//   mem_stall is combinational: (IDLE & (mem_rd|mem_wr)) | BUSY. It rises in the same cycle the op
//     reaches MEM. The op releases in the DONE/ERR cycle.
//   Latency: an ack on the 1st BUSY cycle gives 2 stall cycles. An op holds the pipeline for k+1 cycles,
//     where k = number of BUSY cycles.
//   Ordering: back-to-back ops pass through IDLE between them, so there is no bubble-free issue.
//   An ack and timer expiry in the same cycle: the ack wins and the access completes normally.
//   bus_ack outside BUSY is ignored. A DONE never follows ERR for the same op.
//   rst mid-transaction: bus_req drops at the next edge and the in-flight access is abandoned.
//     No rdata_valid or bus_err is produced.
//   Timer width is clog2(TIMEOUT+1); the timer saturates and never wraps.
// TESTING
//   1 Load, ack on 3rd BUSY cycle, bus_rdata=0xDEADBEEF -> mem_stall high 4 cycles;
//     DONE: rdata=0xDEADBEEF, rdata_valid 1 cycle.
//   2 Store addr=0x100 wdata=0x55 -> bus_we=1, bus_addr/bus_wdata stable until ack; rdata_valid stays 0.
//   3 TIMEOUT=4, no ack -> 4 BUSY cycles, ERR: bus_err 1 cycle, rdata=0, bus_req low, FSM back to IDLE.
//   4 TIMEOUT=4, ack on 4th BUSY cycle (same cycle as expiry) -> DONE, no bus_err.
//   5 rst asserted during BUSY -> next cycle bus_req=0, mem_stall=0, outputs at reset values.
//   6 Load then store back-to-back, mem_rd|mem_wr held through DONE -> two separate transactions;
//     the second bus_req is asserted the cycle after IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store bus controller: one req/ack transaction per op, k+1 stall cycles for k BUSY cycles.
// Holds the pipeline via mem_stall until ack (DONE) or timeout abort (ERR); no request queueing.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // A zero TIMEOUT still needs a legal 1-bit timer even though it is never compared.
  localparam int TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int T_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [TW-1:0] T_LAST = T_LAST_I[TW-1:0];
  localparam logic [TW-1:0] T_MAX  = '1;

  logic [1:0]    state;
  logic [TW-1:0] timer;

  assign bus_req     = (state == S_BUSY);
  assign rdata_valid = (state == S_DONE) && !bus_we;
  assign bus_err     = (state == S_ERR);
  assign mem_stall   = ((state == S_IDLE) && (mem_rd || mem_wr)) || (state == S_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      timer     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_rd || mem_wr) begin
            bus_we    <= mem_wr;
            bus_addr  <= addr;
            bus_wdata <= wdata;
            timer     <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Ack takes priority over a timer expiring in the same cycle.
          if (bus_ack) begin
            if (!bus_we) rdata <= bus_rdata;
            state <= S_DONE;
          end else if ((TIMEOUT != 0) && (timer == T_LAST)) begin
            rdata <= '0;
            state <= S_ERR;
          end else if (timer != T_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        // The op in MEM still shows mem_rd/mem_wr here; it is the one completing, so ignore it.
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4); completions are scoreboarded against a queue.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [31:0] addr, wdata;
  logic        mem_stall;
  logic [31:0] rdata;
  logic        rdata_valid, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .addr       (addr),
    .wdata      (wdata),
    .mem_stall  (mem_stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every rdata_valid / bus_err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (rdata_valid || bus_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", {30'd0, bus_err, rdata_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_kind", {31'd0, bus_err}, {31'd0, e.is_err});
        chk("sb_valid", {31'd0, rdata_valid}, {31'd0, ~e.is_err});
        chk("sb_rdata", rdata, e.data);
      end
    end
  end

  // Drives one op from its IDLE cycle until mem_stall drops; returns in the DONE/ERR cycle with the
  // request still asserted. ack_on = BUSY cycle index that gets bus_ack (0 = never).
  task automatic do_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdv, input int ack_on, output int stalls);
    int busy_n;
    busy_n = 0;
    stalls = 0;
    mem_wr = we;
    mem_rd = !we;
    addr   = a;
    wdata  = wd;
    bus_ack = 1'b0;
    #1;
    while (mem_stall && stalls < 50) begin
      stalls++;
      if (stalls == 1) chk("req_low_in_idle", {31'd0, bus_req}, 32'd0);
      else             chk("req_high_in_busy", {31'd0, bus_req}, 32'd1);
      if (bus_req) begin
        busy_n++;
        chk("bus_addr_stable", bus_addr, a);
        chk("bus_we_stable", {31'd0, bus_we}, {31'd0, we});
        if (we) chk("bus_wdata_stable", bus_wdata, wd);
      end
      if (bus_req && busy_n == ack_on) begin
        bus_ack   = 1'b1;
        bus_rdata = rdv;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
      next_cyc();
    end
    bus_ack = 1'b0;
    if (stalls >= 50) chk("stall_bound_expired", 32'(stalls), 32'd0);
  endtask

  task automatic release_req();
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    next_cyc();
  endtask

  initial begin
    int st;
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    next_cyc(); next_cyc();
    rst = 1'b0;
    #1;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_flags", {30'd0, rdata_valid, bus_err}, 32'd0);

    // Ack outside BUSY must be ignored.
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    next_cyc();
    bus_ack = 1'b0;
    next_cyc();
    chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
    chk("stray_ack_rdata", rdata, 32'd0);

    // 1: load, ack on 3rd BUSY cycle.
    exp_q.push_back('{is_err: 1'b0, data: 32'hDEAD_BEEF});
    do_op(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 3, st);
    chk("t1_stall_cycles", 32'(st), 32'd4);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_valid", {31'd0, rdata_valid}, 32'd1);
    release_req();
    chk("t1_valid_pulse", {31'd0, rdata_valid}, 32'd0);
    chk("t1_rdata_held", rdata, 32'hDEAD_BEEF);

    // 2: store, ack on 2nd BUSY cycle.
    do_op(1'b1, 32'h0000_0100, 32'h0000_0055, 32'h0, 2, st);
    chk("t2_stall_cycles", 32'(st), 32'd3);
    chk("t2_no_valid", {30'd0, rdata_valid, bus_err}, 32'd0);
    chk("t2_rdata_kept", rdata, 32'hDEAD_BEEF);
    release_req();

    // 3: timeout with no ack.
    exp_q.push_back('{is_err: 1'b1, data: 32'h0});
    do_op(1'b0, 32'h0000_0200, 32'h0, 32'h0, 0, st);
    chk("t3_stall_cycles", 32'(st), 32'd5);
    chk("t3_bus_err", {31'd0, bus_err}, 32'd1);
    chk("t3_rdata_zero", rdata, 32'd0);
    chk("t3_req_low", {31'd0, bus_req}, 32'd0);
    release_req();
    chk("t3_err_pulse", {31'd0, bus_err}, 32'd0);
    chk("t3_back_idle", {31'd0, mem_stall}, 32'd0);

    // 4: ack coincides with timer expiry.
    exp_q.push_back('{is_err: 1'b0, data: 32'hCAFE_F00D});
    do_op(1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 4, st);
    chk("t4_stall_cycles", 32'(st), 32'd5);
    chk("t4_no_err", {31'd0, bus_err}, 32'd0);
    chk("t4_rdata", rdata, 32'hCAFE_F00D);
    release_req();

    // 5: reset during BUSY abandons the access.
    mem_rd = 1'b1; addr = 32'h0000_0400;
    next_cyc(); next_cyc();
    chk("t5_busy", {31'd0, bus_req}, 32'd1);
    rst = 1'b1; mem_rd = 1'b0;
    next_cyc();
    chk("t5_req", {31'd0, bus_req}, 32'd0);
    chk("t5_stall", {31'd0, mem_stall}, 32'd0);
    chk("t5_rdata", rdata, 32'd0);
    chk("t5_bus_addr", bus_addr, 32'd0);
    rst = 1'b0;
    next_cyc();
    chk("t5_no_flags", {30'd0, rdata_valid, bus_err}, 32'd0);

    // 6: load then store back-to-back, request held through DONE.
    exp_q.push_back('{is_err: 1'b0, data: 32'h0BAD_F00D});
    do_op(1'b0, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 1, st);
    chk("t6_load_stall", 32'(st), 32'd2);
    chk("t6_load_valid", {31'd0, rdata_valid}, 32'd1);
    next_cyc();
    do_op(1'b1, 32'h0000_0504, 32'hA5A5_5A5A, 32'h0, 1, st);
    chk("t6_store_stall", 32'(st), 32'd2);
    chk("t6_store_no_valid", {31'd0, rdata_valid}, 32'd0);
    release_req();
    next_cyc();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
